// File: rtl/chen_pkg.sv
// Shared constants and types for the Chen attractor UART sample transmitter.
// The frame is one sync byte followed by three big-endian state words.
package chen_pkg;

    localparam int Width    = 32;
    localparam int FracBits = 20;

    localparam logic [7:0] SyncByte = 8'hA5;

    function automatic int frame_bytes(input int word_width);
        return 1 + 3 * (word_width / 8);
    endfunction

    localparam int FrameBytes = frame_bytes(Width);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/chen_uart_tx_byte.sv
// One-byte 8N1 serializer: start bit, eight data bits LSB-first, stop bit.
// At the end of a stop bit it chains straight into the next byte unless `last` is set.
module uart_tx_byte
    import chen_pkg::*;
#(
    parameter int ClksPerBit = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] byte_i,
    input  logic       last,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output tx_state_e  state
);

    localparam int CntW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

    tx_state_e       state_next;
    logic [CntW-1:0] baud_cnt;
    logic [CntW-1:0] baud_next;
    logic [2:0]      bit_cnt;
    logic [2:0]      bit_next;
    logic [7:0]      shift;
    logic [7:0]      shift_next;
    logic            tx_next;
    logic            bit_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            tx       <= tx_next;
            busy     <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        tx_next    = tx;
        done       = 1'b0;
        bit_end    = (baud_cnt == CntMax);

        // The baud counter only runs while a bit is on the line.
        if (state != IDLE) begin
            baud_next = bit_end ? '0 : baud_cnt + CntW'(1);
        end

        case (state)
            IDLE: begin
                if (load) begin
                    shift_next = byte_i;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_next    = shift[0];
                    shift_next = {1'b0, shift[7:1]};
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt == 3'd7) begin
                        tx_next    = 1'b1;
                        bit_next   = 3'd0;
                        state_next = STOP;
                    end else begin
                        tx_next    = shift[0];
                        shift_next = {1'b0, shift[7:1]};
                        bit_next   = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    done = 1'b1;
                    if (last) begin
                        state_next = IDLE;
                    end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        shift_next = byte_i;
                        tx_next    = 1'b0;
                        state_next = START;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/chen_uart_tx.sv
// Captures one (xn, yn, zn) sample and sends it as a 13-byte 8N1 frame:
// sync byte A5, then xn, yn, zn each most-significant byte first.
module chen_uart_tx #(
    parameter int Width      = chen_pkg::Width,
    parameter int ClksPerBit = 434
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [Width-1:0] xn_i,
    input  logic [Width-1:0] yn_i,
    input  logic [Width-1:0] zn_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             drop_o,
    output logic             tx_o
);

    import chen_pkg::*;

    localparam int FrameLen = frame_bytes(Width);
    localparam int IdxW     = $clog2(FrameLen);
    localparam int ShW      = 3 * Width;

    logic [ShW-1:0]  shadow;
    logic [ShW-1:0]  shifted;
    logic [IdxW-1:0] byte_idx;
    logic [7:0]      next_byte;
    logic            accept;
    logic            last_byte;
    logic            byte_done;
    logic            eng_busy;
    tx_state_e       eng_state;

    assign ready_o   = (eng_state == IDLE);
    assign busy_o    = eng_busy;
    assign accept    = valid_i & ready_o;
    assign last_byte = (byte_idx == IdxW'(FrameLen - 1));

    // Byte handed to the serializer on its next load: the sync byte when
    // starting a frame, otherwise shadow byte byte_idx (0-based, MSB first).
    always_comb begin
        shifted   = shadow << (8 * int'(byte_idx));
        next_byte = ready_o ? SyncByte : shifted[ShW-1 -: 8];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shadow   <= '0;
            byte_idx <= '0;
            drop_o   <= 1'b0;
        end else begin
            drop_o <= valid_i & ~ready_o;
            if (accept) begin
                shadow   <= {xn_i, yn_i, zn_i};
                byte_idx <= '0;
            end else if (byte_done) begin
                byte_idx <= last_byte ? '0 : byte_idx + IdxW'(1);
            end
        end
    end

    uart_tx_byte #(
        .ClksPerBit(ClksPerBit)
    ) u_byte (
        .clk   (clk_i),
        .rst_n (rst_i),
        .load  (accept),
        .byte_i(next_byte),
        .last  (last_byte),
        .tx    (tx_o),
        .busy  (eng_busy),
        .done  (byte_done),
        .state (eng_state)
    );

endmodule

// File: tb/tb_chen_uart_tx.sv
// Bench for chen_uart_tx: frame-level model, per-cycle output compare,
// UART byte monitor with expected-byte queue, and directed scenarios.
`timescale 1ns/1ps
module tb_chen_uart_tx;

    localparam int W           = 32;
    localparam int C           = 4;
    localparam int FrameCycles = 130 * C;

    logic         clk     = 1'b0;
    logic         rst_i   = 1'b0;
    logic         valid_i = 1'b0;
    logic [W-1:0] xn_i    = '0;
    logic [W-1:0] yn_i    = '0;
    logic [W-1:0] zn_i    = '0;
    logic         ready_o;
    logic         busy_o;
    logic         drop_o;
    logic         tx_o;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    chen_uart_tx #(
        .Width     (W),
        .ClksPerBit(C)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .valid_i(valid_i),
        .xn_i   (xn_i),
        .yn_i   (yn_i),
        .zn_i   (zn_i),
        .ready_o(ready_o),
        .busy_o (busy_o),
        .drop_o (drop_o),
        .tx_o   (tx_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame model ----------------
    logic       m_active  = 1'b0;
    int         m_cnt     = 0;
    logic       m_drop    = 1'b0;
    int         m_accepts = 0;
    logic       m_bits [0:129];
    logic [7:0] exp_q[$];

    task automatic load_frame(input logic [95:0] s);
        logic [7:0] b;
        for (int i = 0; i < 13; i++) begin
            b = (i == 0) ? 8'hA5 : s[95 - 8 * (i - 1) -: 8];
            exp_q.push_back(b);
            m_bits[10 * i] = 1'b0;
            for (int j = 0; j < 8; j++) m_bits[10 * i + 1 + j] = b[j];
            m_bits[10 * i + 9] = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            m_active = 1'b0;
            m_cnt    = 0;
            m_drop   = 1'b0;
            exp_q.delete();
        end else begin
            m_drop = valid_i && m_active;
            if (m_active) begin
                m_cnt++;
                if (m_cnt == FrameCycles) m_active = 1'b0;
            end else if (valid_i) begin
                load_frame({xn_i, yn_i, zn_i});
                m_active = 1'b1;
                m_cnt    = 0;
                m_accepts++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int busy_run  = 0;
    int last_busy = 0;
    int dut_drops = 0;

    always @(negedge clk) begin
        check("tx", tx_o, m_active ? m_bits[m_cnt / C] : 1'b1);
        check("busy", busy_o, m_active);
        check("ready", ready_o, !m_active);
        check("drop", drop_o, m_drop);
        if (drop_o) dut_drops++;
        if (busy_o) busy_run++;
        else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run  = 0;
        end
    end

    // ---------------- UART monitor + scoreboard ----------------
    int         mon_cnt = -1;
    int         mon_k   = 0;
    logic [7:0] mon_sh  = '0;
    logic [7:0] mon_log[$];

    always @(negedge clk) begin
        if (!rst_i) begin
            mon_cnt = -1;
        end else if (mon_cnt < 0) begin
            if (tx_o == 1'b0) mon_cnt = 0;
        end else begin
            mon_cnt++;
            if (mon_cnt % C == C / 2) begin
                mon_k = mon_cnt / C;
                if (mon_k == 0) begin
                    check("start_bit", tx_o, 1'b0);
                end else if (mon_k <= 8) begin
                    mon_sh[mon_k - 1] = tx_o;
                end else begin
                    check("stop_bit", tx_o, 1'b1);
                    mon_log.push_back(mon_sh);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL byte_unexpected: got %h, expected no byte", mon_sh);
                    end else begin
                        check("byte", mon_sh, exp_q.pop_front());
                    end
                    mon_cnt = -1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        xn_i    = x;
        yn_i    = y;
        zn_i    = z;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", busy_o, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] frame_a [0:12] = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h00, 8'hFF, 8'hF0,
                                   8'h00, 8'h00, 8'h01, 8'h90, 8'h00, 8'h00};

    // ---------------- scenarios ----------------
    initial begin
        rst_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_i = 1'b1;
        repeat (20) @(negedge clk);
        check("reset_tx", tx_o, 1'b1);
        check("reset_busy", busy_o, 1'b0);
        check("reset_ready", ready_o, 1'b1);
        check("reset_drop", drop_o, 1'b0);

        // Single frame; xn changes right after acceptance
        send(32'h0010_0000, 32'hFFF0_0000, 32'h0190_0000);
        check("accept_tx", tx_o, 1'b0);
        check("accept_busy", busy_o, 1'b1);
        check("accept_ready", ready_o, 1'b0);
        xn_i = 32'hDEAD_BEEF;
        wait_idle(FrameCycles + 20);
        check("busy_len", last_busy, 520);
        check("frame_a_len", mon_log.size(), 13);
        for (int i = 0; i < 13; i++) check("frame_a_byte", mon_log[i], frame_a[i]);

        // Overrun at cycles 10 and 300 after acceptance
        send(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F1E_2D3C);
        repeat (9) @(negedge clk);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (289) @(negedge clk);
        send(32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        wait_idle(FrameCycles + 20);
        check("overrun_drops", dut_drops, 2);
        check("overrun_len", mon_log.size(), 26);
        check("overrun_b14", mon_log[14], 8'h12);
        check("overrun_b25", mon_log[25], 8'h3C);

        // Back-to-back: valid on the busy-fall edge, then one cycle later
        send(32'h0000_0001, 32'h8000_0000, 32'h7FFF_FFFF);
        repeat (519) @(negedge clk);
        xn_i    = 32'hCAFE_F00D;
        yn_i    = 32'h0000_FFFF;
        zn_i    = 32'h0102_0304;
        valid_i = 1'b1;
        @(negedge clk);
        check("b2b_drop", drop_o, 1'b1);
        check("b2b_gap_busy", busy_o, 1'b0);
        check("b2b_gap_ready", ready_o, 1'b1);
        @(negedge clk);
        valid_i = 1'b0;
        check("b2b_start_tx", tx_o, 1'b0);
        check("b2b_start_busy", busy_o, 1'b1);
        check("b2b_no_drop", drop_o, 1'b0);
        wait_idle(FrameCycles + 20);
        check("b2b_drops", dut_drops, 3);
        check("b2b_len", mon_log.size(), 52);
        check("b2b_b30", mon_log[30], 8'h01);
        check("b2b_b39", mon_log[39], 8'hA5);
        check("b2b_b40", mon_log[40], 8'hCA);
        check("b2b_b51", mon_log[51], 8'h04);

        // Reset during byte 6
        send(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
        repeat (250) @(posedge clk);
        #2 rst_i = 1'b0;
        #1;
        check("async_rst_tx", tx_o, 1'b1);
        check("async_rst_busy", busy_o, 1'b0);
        check("async_rst_ready", ready_o, 1'b1);
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_len", mon_log.size(), 58);
        send(32'h0A0B_0C0D, 32'h0E0F_1011, 32'h1213_1415);
        wait_idle(FrameCycles + 20);
        check("post_rst_len", mon_log.size(), 71);
        check("post_rst_b58", mon_log[58], 8'hA5);
        check("post_rst_b59", mon_log[59], 8'h0A);
        check("post_rst_b70", mon_log[70], 8'h15);
        check("model_accepts", m_accepts, 6);
        check("exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got timeout, expected scenario completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
